// File: rtl/cle_relabel_pkg.sv
// Shared constants, state encoding and helpers for the label-renumbering pass.
package cle_relabel_pkg;

  localparam int DEF_IMG_PIX = 1024;
  localparam int ADDR_W      = 10;
  localparam int IDX_W       = 4;
  localparam int AREA_W      = 11;
  localparam logic [7:0] OVF_MARK = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CHK,
    WR,
    FIN
  } state_t;

  // Compact object indices are written back as zero-extended 8-bit labels.
  function automatic logic [7:0] idx_to_label(input logic [IDX_W-1:0] idx);
    return {{(8-IDX_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/cle_relabel_if.sv
// Single-port label SRAM bus: the relabeler masters the address/write side.
interface cle_relabel_if;
  import cle_relabel_pkg::*;

  logic [ADDR_W-1:0] sram_a;
  logic [7:0]        sram_d;
  logic              sram_wen;
  logic [7:0]        sram_q;

  modport master (output sram_a, sram_d, sram_wen, input sram_q);
  modport slave  (input sram_a, sram_d, sram_wen, output sram_q);

endinterface

// File: rtl/cle_relabel_label_cam.sv
// Label table: maps original labels to compact indices 1..MAX_OBJ with a parallel lookup.
module cle_label_cam
  import cle_relabel_pkg::*;
#(
  parameter int MAX_OBJ = 15
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic [7:0]       i_label,
  input  logic             i_wr,
  input  logic [IDX_W-1:0] i_wr_idx,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_hit_idx
);

  logic [7:0] r_tag [1:MAX_OBJ];
  logic       r_valid [1:MAX_OBJ];

  always_ff @(posedge i_clk) begin
    for (int i = 1; i <= MAX_OBJ; i++) begin
      if (i_reset || i_clear) begin
        r_valid[i] <= 1'b0;
      end else if (i_wr && (i_wr_idx == IDX_W'(i))) begin
        r_valid[i] <= 1'b1;
      end
    end
  end

  // Tags need no reset: an entry is only consulted once its valid bit is set.
  always_ff @(posedge i_clk) begin
    for (int i = 1; i <= MAX_OBJ; i++) begin
      if (i_wr && (i_wr_idx == IDX_W'(i))) begin
        r_tag[i] <= i_label;
      end
    end
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    o_hit     = 1'b0;
    o_hit_idx = '0;
    for (int i = MAX_OBJ; i >= 1; i--) begin
      if (r_valid[i] && (r_tag[i] == i_label)) begin
        o_hit     = 1'b1;
        o_hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cle_relabel.sv
// Raster-scan relabeler: renumbers nonzero SRAM labels 1,2,... by first appearance and tallies areas.
module cle_relabel
  import cle_relabel_pkg::*;
#(
  parameter int MAX_OBJ = 15,
  parameter int IMG_PIX = DEF_IMG_PIX
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  cle_relabel_if.master     sram,
  output logic              o_done,
  output logic [IDX_W-1:0]  o_obj_cnt,
  output logic              o_overflow,
  input  logic [IDX_W-1:0]  i_area_sel,
  output logic [AREA_W-1:0] o_area_q
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wval;
  logic [IDX_W-1:0]  r_widx;
  logic [IDX_W-1:0]  r_obj_cnt;
  logic              r_overflow;
  logic              r_done;
  logic [AREA_W-1:0] r_area [1:MAX_OBJ];

  logic              w_last;
  logic              w_q_zero;
  logic              w_hit;
  logic [IDX_W-1:0]  w_hit_idx;
  logic              w_room;
  logic [IDX_W-1:0]  w_new_idx;
  logic              w_store;
  logic              w_clear;

  assign w_last    = (r_addr == ADDR_W'(IMG_PIX - 1));
  assign w_q_zero  = (sram.sram_q == 8'h00);
  assign w_room    = (r_obj_cnt < IDX_W'(MAX_OBJ));
  assign w_new_idx = r_obj_cnt + 1'b1;
  assign w_store   = (r_state == CHK) && !w_q_zero && !w_hit && w_room;
  assign w_clear   = (r_state == IDLE) && i_start;

  cle_label_cam #(.MAX_OBJ(MAX_OBJ)) u_cam (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_clear),
    .i_label   (sram.sram_q),
    .i_wr      (w_store),
    .i_wr_idx  (w_new_idx),
    .o_hit     (w_hit),
    .o_hit_idx (w_hit_idx)
  );

  // CHK presents no address; the read issued in RD has already landed on sram_q.
  always_comb begin
    w_next        = r_state;
    sram.sram_a   = '0;
    sram.sram_d   = '0;
    sram.sram_wen = 1'b1;
    case (r_state)
      IDLE: if (i_start) w_next = RD;
      RD: begin
        sram.sram_a = r_addr;
        w_next      = CHK;
      end
      CHK: begin
        if (!w_q_zero)   w_next = WR;
        else if (w_last) w_next = FIN;
        else             w_next = RD;
      end
      WR: begin
        sram.sram_a   = r_addr;
        sram.sram_d   = r_wval;
        sram.sram_wen = 1'b0;
        w_next        = w_last ? FIN : RD;
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wval     <= '0;
      r_widx     <= '0;
      r_obj_cnt  <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 1; i <= MAX_OBJ; i++) r_area[i] <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_addr     <= '0;
            r_obj_cnt  <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 1; i <= MAX_OBJ; i++) r_area[i] <= '0;
          end
        end
        CHK: begin
          if (w_q_zero) begin
            if (!w_last) r_addr <= r_addr + 1'b1;
          end else if (w_hit) begin
            r_wval <= idx_to_label(w_hit_idx);
            r_widx <= w_hit_idx;
          end else if (w_room) begin
            r_wval    <= idx_to_label(w_new_idx);
            r_widx    <= w_new_idx;
            r_obj_cnt <= w_new_idx;
          end else begin
            // Table full: mark the pixel and keep index 0 so no area is counted.
            r_wval     <= OVF_MARK;
            r_widx     <= '0;
            r_overflow <= 1'b1;
          end
        end
        WR: begin
          for (int i = 1; i <= MAX_OBJ; i++) begin
            if (r_widx == IDX_W'(i)) r_area[i] <= r_area[i] + 1'b1;
          end
          if (!w_last) r_addr <= r_addr + 1'b1;
        end
        FIN:     r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_area_q = '0;
    for (int i = 1; i <= MAX_OBJ; i++) begin
      if (i_area_sel == IDX_W'(i)) o_area_q = r_area[i];
    end
  end

  assign o_done     = r_done;
  assign o_obj_cnt  = r_obj_cnt;
  assign o_overflow = r_overflow;

endmodule
